// File: rtl/fifo_word_packer_if.sv
// Stream bundle for fifo_word_packer: FIFO read port, flush request and the
// packed-word valid/ready output with keep/last sideband.
interface fifo_word_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  logic                    fifo_empty;
  logic [IN_W-1:0]         fifo_rdata;
  logic                    fifo_rd_en;
  logic                    flush;
  logic                    m_valid;
  logic                    m_ready;
  logic [IN_W*RATIO-1:0]   m_data;
  logic [RATIO-1:0]        m_keep;
  logic                    m_last;

  modport master (
    input  fifo_empty, fifo_rdata, flush, m_ready,
    output fifo_rd_en, m_valid, m_data, m_keep, m_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, flush, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains a synchronous byte FIFO, packs RATIO lanes per output word, flush emits partial words.
// Optional: PACKER_BIG_ENDIAN_EN places lane 0 in the MSB lane and fills m_keep from the MSB.
module fifo_word_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  fifo_word_packer_if.master bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RATIO);

  typedef enum logic [1:0] {FILL, HOLD, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   iss, lnd;
  logic               flush_pend;
  logic               land_p0;
  logic [OUT_W-1:0]   asm_p0, asm_nxt;
  logic               out_free;
  logic               clr_cnt, pend_clr, load_out, load_last;
  logic [CNT_W-1:0]   load_n;

  // Lane i of the assembly register sits at bits [i*IN_W +: IN_W]; only the
  // first n lanes are emitted, the rest are forced to zero.
  function automatic logic [OUT_W-1:0] pack_word(input logic [OUT_W-1:0] lanes,
                                                 input logic [CNT_W-1:0] n);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(n)) begin
`ifdef PACKER_BIG_ENDIAN_EN
        w[(RATIO-1-i)*IN_W +: IN_W] = lanes[i*IN_W +: IN_W];
`else
        w[i*IN_W +: IN_W] = lanes[i*IN_W +: IN_W];
`endif
      end
    end
    return w;
  endfunction

  function automatic logic [RATIO-1:0] keep_mask(input logic [CNT_W-1:0] n);
    logic [RATIO-1:0] k;
    k = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(n)) begin
`ifdef PACKER_BIG_ENDIAN_EN
        k[RATIO-1-i] = 1'b1;
`else
        k[i] = 1'b1;
`endif
      end
    end
    return k;
  endfunction

  assign out_free       = !bus.m_valid || bus.m_ready;
  assign bus.fifo_rd_en = !rst && !bus.fifo_empty && (iss < FULL) &&
                          (state == FILL) && !flush_pend;

  always_comb begin
    asm_nxt   = asm_p0;
    state_nxt = state;
    clr_cnt   = 1'b0;
    pend_clr  = 1'b0;
    load_out  = 1'b0;
    load_last = 1'b0;
    load_n    = '0;
    if (land_p0) asm_nxt[int'(lnd)*IN_W +: IN_W] = bus.fifo_rdata;
    case (state)
      FILL: begin
        if (land_p0 && lnd == LAST) begin
          if (out_free) begin
            load_out = 1'b1;
            load_n   = FULL;
            clr_cnt  = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end else if (flush_pend && iss == lnd) begin
          // Nothing in flight: emit directly when possible, park in FLUSH otherwise.
          if (lnd == '0) begin
            pend_clr = 1'b1;
            clr_cnt  = 1'b1;
          end else if (out_free) begin
            load_out  = 1'b1;
            load_n    = lnd;
            load_last = 1'b1;
            pend_clr  = 1'b1;
            clr_cnt   = 1'b1;
          end else begin
            state_nxt = FLUSH;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          load_out  = 1'b1;
          load_n    = FULL;
          clr_cnt   = 1'b1;
          state_nxt = FILL;
        end
      end
      FLUSH: begin
        if (out_free) begin
          load_out  = 1'b1;
          load_n    = lnd;
          load_last = 1'b1;
          pend_clr  = 1'b1;
          clr_cnt   = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // p0: control state, counters and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      iss         <= '0;
      lnd         <= '0;
      flush_pend  <= 1'b0;
      land_p0     <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_keep  <= '0;
      bus.m_last  <= 1'b0;
    end else begin
      state   <= state_nxt;
      land_p0 <= bus.fifo_rd_en;
      if (clr_cnt) begin
        iss <= '0;
        lnd <= '0;
      end else begin
        iss <= iss + CNT_W'(bus.fifo_rd_en);
        lnd <= lnd + CNT_W'(land_p0);
      end
      if (pend_clr)       flush_pend <= 1'b0;
      else if (bus.flush) flush_pend <= 1'b1;
      if (load_out) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= pack_word(asm_nxt, load_n);
        bus.m_keep  <= keep_mask(load_n);
        bus.m_last  <= load_last;
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end

  // p0: assembly lanes, stale lanes are masked off at emit time
  always_ff @(posedge clk) begin
    asm_p0 <= asm_nxt;
  end
endmodule
